// File: rtl/sm83_alu_flags_if.sv
// Flag-unit bus: ALU status in, flag select/enable controls, flag values out.
// The controller side owns the master modport; the flag register block is the slave.
interface sm83_alu_flags_if;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_half_carry;
  logic       shift_out;
  logic       daa_carry_out;
  logic       n_in;
  logic [1:0] z_sel;
  logic [1:0] h_sel;
  logic [2:0] c_sel;
  logic       n_we;
  logic       pri_we;
  logic [1:0] cin_sel;
  logic       flags_load;
  logic [7:0] db_in;
  logic [7:0] flags_db;
  logic       zero;
  logic       carry;
  logic       daa_carry;
  logic       flag_n;
  logic       pri_carry;
  logic       alu_carry_in;

  modport master (
    output alu_zero, alu_carry, alu_half_carry, shift_out, daa_carry_out, n_in,
           z_sel, h_sel, c_sel, n_we, pri_we, cin_sel, flags_load, db_in,
    input  flags_db, zero, carry, daa_carry, flag_n, pri_carry, alu_carry_in
  );

  modport slave (
    input  alu_zero, alu_carry, alu_half_carry, shift_out, daa_carry_out, n_in,
           z_sel, h_sel, c_sel, n_we, pri_we, cin_sel, flags_load, db_in,
    output flags_db, zero, carry, daa_carry, flag_n, pri_carry, alu_carry_in
  );
endinterface

// File: rtl/sm83_alu_flags.sv
// SM83 flag registers Z/N/H/C plus the primary carry buffer P feeding the ALU carry-in.
// Flag outputs come straight from flops; only flags_db and alu_carry_in are combinational.
module sm83_alu_flags (
  input logic              clk,
  input logic              reset,
  sm83_alu_flags_if.slave  bus
);
  logic z_q, n_q, h_q, c_q, p_q;
  logic z_d, n_d, h_d, c_d, p_d;

  always_comb begin
    z_d = z_q;
    h_d = h_q;
    c_d = c_q;
    n_d = n_q;
    p_d = bus.pri_we ? bus.alu_carry : p_q;

    unique case (bus.z_sel)
      2'd0:    z_d = bus.alu_zero;
      2'd1:    z_d = 1'b0;
      2'd2:    z_d = 1'b1;
      default: z_d = z_q;
    endcase

    unique case (bus.h_sel)
      2'd0:    h_d = bus.alu_half_carry;
      2'd1:    h_d = 1'b0;
      2'd2:    h_d = 1'b1;
      default: h_d = h_q;
    endcase

    // DAA can only raise C, never drop it
    case (bus.c_sel)
      3'd0:    c_d = bus.alu_carry;
      3'd1:    c_d = bus.shift_out;
      3'd2:    c_d = c_q | bus.daa_carry_out;
      3'd3:    c_d = ~c_q;
      3'd4:    c_d = 1'b1;
      default: c_d = c_q;
    endcase

    if (bus.n_we) n_d = bus.n_in;

    // POP AF overrides every per-flag select; P is not part of AF
    if (bus.flags_load) begin
      z_d = bus.db_in[7];
      n_d = bus.db_in[6];
      h_d = bus.db_in[5];
      c_d = bus.db_in[4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      h_q <= 1'b0;
      c_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      h_q <= h_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

  // Carry-in reads registered C/P so CCF with cin_sel=C sees the pre-edge value
  always_comb begin
    unique case (bus.cin_sel)
      2'd0:    bus.alu_carry_in = 1'b0;
      2'd1:    bus.alu_carry_in = 1'b1;
      2'd2:    bus.alu_carry_in = c_q;
      default: bus.alu_carry_in = p_q;
    endcase
  end

  assign bus.flags_db  = {z_q, n_q, h_q, c_q, 4'b0000};
  assign bus.zero      = z_q;
  assign bus.carry     = c_q;
  assign bus.daa_carry = h_q;
  assign bus.flag_n    = n_q;
  assign bus.pri_carry = p_q;
endmodule

// File: doc/sm83_alu_flags.md
SM83_ALU_FLAGS -- requirements
Module: sm83_alu_flags

Interface
REQ-001 SHALL have one clock, `clk`; reset is asynchronous and active-high, named `reset`.
REQ-002 Ports, as name  direction  width  meaning:
- `clk`  in  1  core clock.
- `reset`  in  1  async active-high reset.
- `alu_zero`  in  1  ALU result-zero.
- `alu_carry`  in  1  ALU carry-out.
- `alu_half_carry`  in  1  ALU nibble carry-out.
- `shift_out`  in  1  shift carry from ALU control.
- `daa_carry_out`  in  1  DAA carry from ALU control.
- `n_in`  in  1  subtract value for N.
REQ-003 Control and data ports, as name  direction  width  meaning:
- `z_sel`  in  2  Z source.
- `h_sel`  in  2  H source.
- `c_sel`  in  3  C source.
- `n_we`  in  1  N write enable.
- `pri_we`  in  1  primary carry capture enable.
- `cin_sel`  in  2  ALU carry-in source.
- `flags_load`  in  1  load flags from `db_in` (POP AF).
- `db_in`  in  8  data bus in.
- `flags_db`  out  8  flags byte {Z,N,H,C,4'b0000}.
REQ-004 Outputs to ALU control and ALU, as name  direction  width  meaning:
- `zero`  out  1  Z flag.
- `carry`  out  1  C flag.
- `daa_carry`  out  1  H flag.
- `flag_n`  out  1  N flag.
- `pri_carry`  out  1  primary carry buffer.
- `alu_carry_in`  out  1  combinational ALU carry-in.

Function
REQ-005 SHALL hold four flag registers Z, N, H, C plus one primary carry buffer P; all update only on posedge `clk`, visible one cycle after the controlling inputs.
REQ-006 Z update by `z_sel`: 0 = `alu_zero`; 1 = clear; 2 = set; 3 = hold.
REQ-007 H update by `h_sel`: 0 = `alu_half_carry`; 1 = clear; 2 = set; 3 = hold.
REQ-008 C update by `c_sel`:
- 0 = `alu_carry`.
- 1 = `shift_out`.
- 2 = C OR `daa_carry_out` (DAA never clears C).
- 3 = !C (CCF).
- 4 = set (SCF).
- 5..7 = hold.
REQ-009 N SHALL load `n_in` when `n_we`=1, else hold.
REQ-010 P SHALL capture `alu_carry` when `pri_we`=1, else hold; P is independent of the C flag.
REQ-011 `alu_carry_in` SHALL be combinational from `cin_sel`: 0 = 0; 1 = 1; 2 = C; 3 = P.
- Uses register values, not same-cycle next values.
REQ-012 `flags_load`=1 SHALL load Z,N,H,C from `db_in[7:4]` and override `z_sel`/`h_sel`/`c_sel`/`n_we` in that cycle.
- `db_in[3:0]` ignored; P unaffected.
REQ-013 `flags_db` SHALL equal {Z,N,H,C,4'b0000} combinationally; the low nibble is always 0.
REQ-014 `zero`, `carry`, `daa_carry`, `flag_n` SHALL be direct register outputs with no combinational path from any input.
REQ-015 Simultaneous `pri_we` and C update SHALL both take effect from the same `alu_carry` sample.
REQ-016 Same-cycle `c_sel`=3 with `cin_sel`=2 SHALL drive the old C on `alu_carry_in`; C inverts at the edge.

Reset
REQ-017 Asserting `reset` SHALL asynchronously clear Z, N, H, C, P to 0, giving `flags_db`=8'h00 and `alu_carry_in`=`cin_sel`==1.
- Applies mid-operation and overrides `flags_load`.
REQ-018 After `reset` deasserts, the first posedge SHALL perform normal updates.

Verification
REQ-019 Reset, then `flags_load`=1 with `db_in`=8'hFF -> `flags_db`=8'hF0 next cycle; P=0.
REQ-020 `c_sel`=0, `alu_carry`=1, `pri_we`=1, then `cin_sel`=3 and `c_sel`=3 -> `alu_carry_in`=1; C=0 after the second edge; P=1.
REQ-021 C=0, `c_sel`=2, `daa_carry_out`=1 -> C=1; then `c_sel`=2, `daa_carry_out`=0 -> C stays 1.
REQ-022 `z_sel`=0, `alu_zero`=1, `h_sel`=2, `n_we`=1, `n_in`=1, `c_sel`=4 simultaneously -> `flags_db`=8'hF0.
REQ-023 `flags_load`=1, `db_in`=8'h50, `c_sel`=4 in the same cycle -> `flags_db`=8'h50 (load wins).
REQ-024 `reset` pulsed between edges with flags=8'hF0 and P=1 -> immediate `flags_db`=8'h00, `pri_carry`=0, with no clock edge.
